inst_fetch_queue: RTL

Parametrised instruction-fetch front end for the 5-stage MIPS pipeline. It replaces the single-PC IF stage with a fetch engine that keeps up to DEPTH requests in flight to an instruction memory with variable latency. Returned instructions are buffered in an in-order queue, and the decode stage drains that queue through a valid/ready handshake. A branch redirect from the MEM stage flushes all queued entries and silently discards responses that are still in flight.

---
 rtl/inst_fetch_queue_pkg.sv | 12 +
 rtl/inst_fetch_queue_if.sv | 29 ++
 rtl/fetch_queue_ram.sv | 64 ++++++
 rtl/inst_fetch_queue.sv | 137 +++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared fetch-path defaults
// Purpose: default widths, depth and PC constants used by the fetch queue,
//          its storage and its memory-side interface.
package inst_fetch_queue_pkg;

  localparam int          IFQ_ADDR_W   = 32;
  localparam int          IFQ_DATA_W   = 32;
  localparam int          IFQ_DEPTH    = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          PC_STEP_DEF  = 4;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// rtl/inst_fetch_queue_if.sv - instruction memory request/response bundle
// Purpose: groups the fetch-side instruction memory signals.
// Ports:
//   imem_req/imem_addr   request valid and fetch address (fetch side drives)
//   imem_gnt             request accepted this cycle (memory drives)
//   imem_rvalid/rdata    in-order response (memory drives)
// Modports: master = fetch engine, slave = instruction memory.
interface inst_fetch_queue_if
  import inst_fetch_queue_pkg::*;
#(
  parameter int ADDR_W = IFQ_ADDR_W,
  parameter int DATA_W = IFQ_DATA_W
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_queue_ram.sv
// rtl/fetch_queue_ram.sv - fetch queue entry storage
// Purpose: DEPTH entries of {addr, inst, filled}.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clear_all             drop every filled bit (branch flush)
//   alloc_en/idx/addr     allocate entry: record address, mark unfilled
//   fill_en/idx/inst      write returned instruction, mark filled
//   pop_en                release the entry at rd_idx (head)
//   rd_idx/addr/inst/filled  head read port (combinational)
module fetch_queue_ram #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_all,
  input  logic              alloc_en,
  input  logic [PTR_W-1:0]  alloc_idx,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic              fill_en,
  input  logic [PTR_W-1:0]  fill_idx,
  input  logic [DATA_W-1:0] fill_inst,
  input  logic              pop_en,
  input  logic [PTR_W-1:0]  rd_idx,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_inst,
  output logic              rd_filled
);
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] inst_q [DEPTH];
  logic [DEPTH-1:0]  filled_q;

  // Alloc, fill and pop never target the same entry in one cycle: alloc
  // uses a free slot, fill an allocated unfilled one, pop a filled head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        inst_q[i] <= '0;
      end
      filled_q <= '0;
    end else if (clear_all) begin
      filled_q <= '0;
    end else begin
      if (alloc_en) begin
        addr_q[alloc_idx]   <= alloc_addr;
        filled_q[alloc_idx] <= 1'b0;
      end
      if (fill_en) begin
        inst_q[fill_idx]   <= fill_inst;
        filled_q[fill_idx] <= 1'b1;
      end
      if (pop_en) begin
        filled_q[rd_idx] <= 1'b0;
      end
    end
  end

  assign rd_addr   = addr_q[rd_idx];
  assign rd_inst   = inst_q[rd_idx];
  assign rd_filled = filled_q[rd_idx];
endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - multi-request instruction fetch queue
// Purpose: keeps up to DEPTH fetches in flight to a variable-latency
//          instruction memory, buffers responses in order and hands them to
//          decode over valid/ready. A redirect flushes the queue and drops
//          responses still in flight.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   imem (master)                imem_req/addr/gnt/rvalid/rdata
//   redirect_valid/addr          taken branch from MEM: flush and refetch
//   out_valid/ready              head handshake toward decode
//   out_inst/addr/addr_next      head instruction, its address, address+step
//   occupancy                    allocated entries, filled or not
// Build option: INST_FETCH_BYPASS_EN - a response for the single unfilled
//   entry of an otherwise empty queue is forwarded to out_* in the same cycle.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int                ADDR_W   = IFQ_ADDR_W,
  parameter int                DATA_W   = IFQ_DATA_W,
  parameter int                DEPTH    = IFQ_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int                PC_STEP  = PC_STEP_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inst_fetch_queue_if.master   imem,
  input  logic                 redirect_valid,
  input  logic [ADDR_W-1:0]    redirect_addr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_inst,
  output logic [ADDR_W-1:0]    out_addr,
  output logic [ADDR_W-1:0]    out_addr_next,
  output logic [CNT_W-1:0]     occupancy
);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [PTR_W-1:0]  head_ptr, fill_ptr, alloc_ptr;
  logic [CNT_W-1:0]  alloc_cnt, inflight, discard_cnt;

  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_inst;
  logic              head_filled;

  logic accept, resp, resp_drop, resp_keep;
  logic bypass_hit, bypass_take, fill_wr, drain;

  // Held low through reset so nothing is requested before the memory is up.
  assign imem.imem_req  = rst_n & ~redirect_valid & (alloc_cnt < DEPTH_C) & (inflight < DEPTH_C);
  assign imem.imem_addr = fetch_pc;
  assign accept         = imem.imem_req & imem.imem_gnt;

  // A response with nothing in flight is a memory protocol error: ignored.
  assign resp      = imem.imem_rvalid & (inflight != '0);
  assign resp_drop = resp & (discard_cnt != '0);
  assign resp_keep = resp & (discard_cnt == '0) & ~redirect_valid;

`ifdef INST_FETCH_BYPASS_EN
  assign bypass_hit = resp_keep & (alloc_cnt == CNT_W'(1)) & ~head_filled;
`else
  assign bypass_hit = 1'b0;
`endif

  assign out_valid     = (head_filled | bypass_hit) & ~redirect_valid;
  assign out_inst      = bypass_hit ? imem.imem_rdata : head_inst;
  assign out_addr      = head_addr;
  assign out_addr_next = head_addr + ADDR_W'(PC_STEP);
  assign occupancy     = alloc_cnt;

  assign drain       = out_valid & out_ready;
  // A forwarded response consumed immediately never lands in storage, but
  // the fill pointer still has to step past its entry.
  assign bypass_take = bypass_hit & out_ready;
  assign fill_wr     = resp_keep & ~bypass_take;

  fetch_queue_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_all (redirect_valid),
    .alloc_en  (accept),
    .alloc_idx (alloc_ptr),
    .alloc_addr(fetch_pc),
    .fill_en   (fill_wr),
    .fill_idx  (fill_ptr),
    .fill_inst (imem.imem_rdata),
    .pop_en    (drain),
    .rd_idx    (head_ptr),
    .rd_addr   (head_addr),
    .rd_inst   (head_inst),
    .rd_filled (head_filled)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      head_ptr    <= '0;
      fill_ptr    <= '0;
      alloc_ptr   <= '0;
      alloc_cnt   <= '0;
      inflight    <= '0;
      discard_cnt <= '0;
    end else if (redirect_valid) begin
      // No issue or drain this cycle; everything still outstanding after
      // this cycle's response (if any) belongs to the old path.
      fetch_pc    <= redirect_addr;
      head_ptr    <= '0;
      fill_ptr    <= '0;
      alloc_ptr   <= '0;
      alloc_cnt   <= '0;
      inflight    <= inflight - CNT_W'(resp);
      discard_cnt <= inflight - CNT_W'(resp);
    end else begin
      if (accept) begin
        fetch_pc  <= fetch_pc + ADDR_W'(PC_STEP);
        alloc_ptr <= alloc_ptr + PTR_W'(1);
      end
      if (fill_wr | bypass_take) begin
        fill_ptr <= fill_ptr + PTR_W'(1);
      end
      if (drain) begin
        head_ptr <= head_ptr + PTR_W'(1);
      end
      alloc_cnt <= alloc_cnt + CNT_W'(accept) - CNT_W'(drain);
      inflight  <= inflight + CNT_W'(accept) - CNT_W'(resp);
      if (resp_drop) begin
        discard_cnt <= discard_cnt - CNT_W'(1);
      end
    end
  end
endmodule
